// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds the FSM state enum and default sizing constants.
package dmem_pkg;

  localparam int DMEM_ADDR_W  = 13;
  localparam int DMEM_DATA_W  = 32;
  localparam int DMEM_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous byte-strobed write, combinational read.
// Ports: CLK, WE/BE/WADDR/WDATA write port, RADDR/RDATA read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic                CLK,
  input  logic                WE,
  input  logic [DATA_W/8-1:0] BE,
  input  logic [ADDR_W-1:0]   WADDR,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [ADDR_W-1:0]   RADDR,
  output logic [DATA_W-1:0]   RDATA
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (WE) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (BE[b]) begin
          mem[WADDR][b*8 +: 8] <= WDATA[b*8 +: 8];
        end
      end
    end
  end

  assign RDATA = mem[RADDR];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: REQ valid/ready in, RSP valid/ready out.
// Optional REQ_BE byte strobes when DMEM_BYTE_STROBE_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic                CLK,
  input  logic                RST_X,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic                REQ_WE,
  input  logic [31:0]         REQ_ADDR,
  input  logic [DATA_W-1:0]   REQ_WDATA,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [DATA_W/8-1:0] REQ_BE,
`endif
  output logic                RSP_VALID,
  input  logic                RSP_READY,
  output logic [DATA_W-1:0]   RSP_RDATA,
  output logic                RSP_ERR
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  dmem_state_e state, state_n;
  logic [3:0]  cnt, cnt_n;

  logic [ADDR_W-1:0]   widx;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W/8-1:0] be;
  logic                mis;
  logic                accept;
  logic                done;
  logic                unused_addr;

  assign widx        = REQ_ADDR[ADDR_W+1:2];
  assign mis         = |REQ_ADDR[1:0];
  assign unused_addr = ^REQ_ADDR[31:ADDR_W+2];
  assign accept      = (state == IDLE) && REQ_VALID;
  assign done        = (state == RESP) && RSP_READY;

`ifdef DMEM_BYTE_STROBE_EN
  assign be = REQ_BE;
`else
  assign be = '1;
`endif

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .CLK   (CLK),
    .WE    (accept && REQ_WE && !mis && RST_X),
    .BE    (be),
    .WADDR (widx),
    .WDATA (REQ_WDATA),
    .RADDR (widx),
    .RDATA (rd_word)
  );

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (REQ_VALID) begin
          if (LATENCY == 1) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = LAT_M1;
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = RESP;
      end
      RESP: begin
        if (RSP_READY) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Response payload is fixed at acceptance and held until consumed.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else if (accept) begin
      RSP_RDATA <= (REQ_WE || mis) ? '0 : rd_word;
      RSP_ERR   <= mis;
    end else if (done) begin
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end
  end

  assign REQ_READY = (state == IDLE);
  assign RSP_VALID = (state == RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2 and LATENCY=1 instances).
// Byte-strobe expectations follow DMEM_BYTE_STROBE_EN.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        v0, v1, we, rsp_ready;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        rdy0, val0, err0;
  logic        rdy1, val1, err1;
  logic [31:0] rd0, rd1;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W (13), .DATA_W (32), .LATENCY (2)
  ) u0 (
    .CLK       (clk),
    .RST_X     (rst_x),
    .REQ_VALID (v0),
    .REQ_READY (rdy0),
    .REQ_WE    (we),
    .REQ_ADDR  (addr),
    .REQ_WDATA (wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .REQ_BE    (be),
`endif
    .RSP_VALID (val0),
    .RSP_READY (rsp_ready),
    .RSP_RDATA (rd0),
    .RSP_ERR   (err0)
  );

  dmem_responder #(
    .ADDR_W (13), .DATA_W (32), .LATENCY (1)
  ) u1 (
    .CLK       (clk),
    .RST_X     (rst_x),
    .REQ_VALID (v1),
    .REQ_READY (rdy1),
    .REQ_WE    (we),
    .REQ_ADDR  (addr),
    .REQ_WDATA (wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .REQ_BE    (be),
`endif
    .RSP_VALID (val1),
    .RSP_READY (rsp_ready),
    .RSP_RDATA (rd1),
    .RSP_ERR   (err1)
  );

  // Issue one request, wait for its response, then consume it.
  task automatic do_req(
    input  bit          sel,
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  b,
    output int          lat,
    output logic [31:0] rd,
    output logic        err
  );
    @(negedge clk);
    we = w; addr = a; wdata = d; be = b;
    rsp_ready = 1'b0;
    if (sel) v1 = 1'b1;
    else     v0 = 1'b1;
    @(posedge clk);
    #1 v0 = 1'b0; v1 = 1'b0;
    lat = -1; rd = 'x; err = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (sel ? val1 : val0) begin
        lat = i;
        rd  = sel ? rd1 : rd0;
        err = sel ? err1 : err0;
        break;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_x = 1'b0; v0 = 1'b0; v1 = 1'b0;
    we = 1'b0; addr = '0; wdata = '0;
    be = 4'hF; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_x = 1'b1;
    total++;
    if (rdy0 !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b want=1", rdy0);
    end
    total++;
    if (val0 !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b want=0", val0);
    end
    total++;
    if (rd0 !== 32'h0) begin
      bad++; $display("FAIL rst_rdata got=%h want=0", rd0);
    end
    total++;
    if (err0 !== 1'b0 || rdy1 !== 1'b1) begin
      bad++;
      $display("FAIL rst_err_rdy1 got=%b/%b want=0/1", err0, rdy1);
    end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic err;
    do_req(0, 1'b1, 32'h0C, 32'h8, 4'hF, lat, rd, err);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL sw_lat got=%0d want=2", lat);
    end
    total++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      bad++; $display("FAIL sw_rsp got=%h/%b want=0/0", rd, err);
    end
    @(negedge clk);
    total++;
    if (val0 !== 1'b0 || rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL sw_clear got=%b/%b want=0/1", val0, rdy0);
    end
    do_req(0, 1'b0, 32'h0C, 32'h0, 4'hF, lat, rd, err);
    total++;
    if (rd !== 32'h8) begin
      bad++; $display("FAIL lw_data got=%h want=00000008", rd);
    end
    total++;
    if (lat !== 2 || err !== 1'b0) begin
      bad++; $display("FAIL lw_lat got=%0d/%b want=2/0", lat, err);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    @(negedge clk);
    we = 1'b0; addr = 32'h0C; rsp_ready = 1'b0; v0 = 1'b1;
    @(posedge clk);
    #1 v0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (val0) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL bp_timeout got=0 want=1");
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (val0 !== 1'b1 || rd0 !== 32'h8 || rdy0 !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got=%b/%h/%b want=1/00000008/0",
                 k, val0, rd0, rdy0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    total++;
    if (val0 !== 1'b0 || rd0 !== 32'h0 || rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got=%b/%h/%b want=0/0/1",
               val0, rd0, rdy0);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic err;
    do_req(0, 1'b1, 32'h0E, 32'hDEADBEEF, 4'hF, lat, rd, err);
    total++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL mis_rsp got=%b/%h want=1/0", err, rd);
    end
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL mis_lat got=%0d want=2", lat);
    end
    do_req(0, 1'b0, 32'h0C, 32'h0, 4'hF, lat, rd, err);
    total++;
    if (rd !== 32'h8 || err !== 1'b0) begin
      bad++;
      $display("FAIL mis_keep got=%h/%b want=00000008/0", rd, err);
    end
  endtask

  task automatic test_alias();
    int lat; logic [31:0] rd; logic err;
    do_req(0, 1'b1, 32'h0000_8004, 32'h11, 4'hF, lat, rd, err);
    do_req(0, 1'b0, 32'h4, 32'h0, 4'hF, lat, rd, err);
    total++;
    if (rd !== 32'h11) begin
      bad++; $display("FAIL alias got=%h want=00000011", rd);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int lat; logic [31:0] rd; logic err;
    @(negedge clk);
    we = 1'b0; addr = 32'h4; rsp_ready = 1'b0; v0 = 1'b1;
    @(posedge clk);
    #1 v0 = 1'b0;
    @(negedge clk);
    rst_x = 1'b0;
    seen = val0;
    @(negedge clk);
    seen = seen | val0;
    rst_x = 1'b1;
    @(negedge clk);
    total++;
    if (rdy0 !== 1'b1) begin
      bad++; $display("FAIL rmid_ready got=%b want=1", rdy0);
    end
    for (int i = 0; i < 4; i++) begin
      seen = seen | val0;
      @(negedge clk);
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL rmid_valid got=%b want=0", seen);
    end
    do_req(0, 1'b0, 32'h4, 32'h0, 4'hF, lat, rd, err);
    total++;
    if (rd !== 32'h11) begin
      bad++; $display("FAIL rmid_keep got=%h want=00000011", rd);
    end
  endtask

  task automatic test_latency1();
    int lat; logic [31:0] rd; logic err;
    logic [31:0] exp;
`ifdef DMEM_BYTE_STROBE_EN
    exp = 32'hAABBCC11;
`else
    exp = 32'h00000011;
`endif
    do_req(1, 1'b1, 32'h10, 32'hAABBCCDD, 4'hF, lat, rd, err);
    total++;
    if (lat !== 1 || err !== 1'b0) begin
      bad++; $display("FAIL l1_sw1 got=%0d/%b want=1/0", lat, err);
    end
    do_req(1, 1'b1, 32'h10, 32'h00000011, 4'h1, lat, rd, err);
    total++;
    if (lat !== 1) begin
      bad++; $display("FAIL l1_sw2 got=%0d want=1", lat);
    end
    do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, err);
    total++;
    if (rd !== exp) begin
      bad++; $display("FAIL l1_lw got=%h want=%h", rd, exp);
    end
    total++;
    if (lat !== 1) begin
      bad++; $display("FAIL l1_lat got=%0d want=1", lat);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_backpressure();
    test_misaligned();
    test_alias();
    test_reset_mid();
    test_latency1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
